// File: rtl/sparse_decompression.sv
// Sparse vector decompressor: scatters packed non-zero values back to their dense
// lane positions (one per cycle) and presents the rebuilt vector on a valid/ready port.
module sparse_decompression #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*DATA_W-1:0]   data_in,
  input  logic [LANES-1:0]          index_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic [LANES*DATA_W-1:0]   data_out,
  output logic [CNT_W-1:0]          nnz_out,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic                      busy
);

  localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]        nnz_q, nnz_d;
  logic                    valid_q, valid_d;
  logic [DATA_W-1:0]       pk_q [LANES];
  logic [DATA_W-1:0]       pk_d [LANES];

  logic [PTR_W-1:0]        lo;
  logic                    found;
  logic [LANES-1:0]        mask_clr;
  logic [CNT_W-1:0]        cnt;

  assign ready_in  = (state_q == IDLE);
  assign busy      = !ready_in;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign nnz_out   = nnz_q;

  // Lowest set bit of the scan mask, the mask with it cleared, and the input popcount.
  always_comb begin
    lo    = '0;
    found = 1'b0;
    cnt   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mask_q[i] && !found) begin
        lo    = PTR_W'(i);
        found = 1'b1;
      end
      cnt = cnt + CNT_W'(index_in[i]);
    end
    mask_clr     = mask_q;
    mask_clr[lo] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    nnz_d   = nnz_q;
    valid_d = valid_q;
    pk_d    = pk_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            pk_d[i] = data_in[i*DATA_W +: DATA_W];
          end
          mask_d = index_in;
          data_d = '0;
          ptr_d  = '0;
          nnz_d  = cnt;
          if (index_in != '0) begin
            state_d = EXPAND;
          end else begin
            state_d = OUTPUT;
            valid_d = 1'b1;
          end
        end
      end
      EXPAND: begin
        data_d[lo*DATA_W +: DATA_W] = pk_q[ptr_q];
        mask_d = mask_clr;
        // Pointer holds on the final element so a full bitmap never wraps it past LANES-1.
        if (mask_clr == '0) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      OUTPUT: begin
        if (ready_out) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      nnz_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      nnz_q   <= nnz_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    pk_q <= pk_d;
  end

endmodule

// File: tb/tb_sparse_decompression.sv
// Directed plus randomized bench for sparse_decompression, checked against a
// bitmap-walk reference model with immediate assertions.
module tb_sparse_decompression;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned VW     = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [VW-1:0]    data_in;
  logic [LANES-1:0] index_in;
  logic             valid_in;
  logic             ready_in;
  logic [VW-1:0]    data_out;
  logic [CNT_W-1:0] nnz_out;
  logic             valid_out;
  logic             ready_out;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  sparse_decompression #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .index_in(index_in),
    .valid_in(valid_in), .ready_in(ready_in), .data_out(data_out),
    .nnz_out(nnz_out), .valid_out(valid_out), .ready_out(ready_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the bitmap from lane 0 upward, consuming packed elements in order.
  function automatic logic [VW-1:0] expand_ref(input logic [LANES-1:0] idx, input logic [VW-1:0] pk);
    logic [VW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 0; i < LANES; i++) begin
      if (idx[i]) begin
        d[i*DATA_W +: DATA_W] = pk[k*DATA_W +: DATA_W];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector, follow it to its output handshake. hold_next keeps valid_in
  // asserted with the following vector presented while this one is in flight.
  task automatic run_vec(input logic [LANES-1:0] idx, input logic [VW-1:0] pk, input int bp,
                         input bit hold_next, input logic [LANES-1:0] nidx, input logic [VW-1:0] npk);
    logic [VW-1:0] exp;
    int n;
    int p;
    bit rdy_bad;
    exp = expand_ref(idx, pk);
    p = $countones(idx);
    n = 0;
    while (!ready_in && n < 50) begin tick(); n++; end
    chk("ready_before_accept", {255'd0, ready_in}, 1);
    valid_in = 1'b1; index_in = idx; data_in = pk;
    tick();
    if (hold_next) begin
      index_in = nidx; data_in = npk;
    end else begin
      valid_in = 1'b0; index_in = LANES'($urandom); data_in = rand_vec();
    end
    chk("busy_after_accept", {255'd0, busy}, 1);
    n = 0;
    rdy_bad = 1'b0;
    while (!valid_out && n < 40) begin
      if (ready_in) rdy_bad = 1'b1;
      if (!hold_next) begin index_in = LANES'($urandom); data_in = rand_vec(); end
      tick();
      n++;
    end
    chk("latency", VW'(n), VW'(p));
    chk("ready_in_low_expand", {255'd0, rdy_bad}, 0);
    chk("data_out", data_out, exp);
    chk("nnz_out", VW'(nnz_out), VW'(p));
    for (int c = 0; c < bp; c++) begin
      tick();
      chk("bp_valid_held", {255'd0, valid_out}, 1);
      chk("bp_data_stable", data_out, exp);
      chk("bp_ready_in_low", {255'd0, ready_in}, 0);
    end
    ready_out = 1'b1;
    tick();
    ready_out = 1'b0;
    chk("valid_drop", {255'd0, valid_out}, 0);
    chk("ready_in_rise", {255'd0, ready_in}, 1);
    chk("data_kept", data_out, exp);
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [LANES-1:0] idx;
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
    index_in = '0; data_in = '0;
    tick(); tick();
    chk("rst_valid", {255'd0, valid_out}, 0);
    chk("rst_ready", {255'd0, ready_in}, 1);
    chk("rst_busy", {255'd0, busy}, 0);
    chk("rst_data", data_out, '0);
    chk("rst_nnz", VW'(nnz_out), '0);
    rst_n = 1'b1;
    tick();

    // Dense pass-through
    for (int k = 0; k < LANES; k++) v[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
    run_vec(16'hFFFF, v, 0, 1'b0, '0, '0);

    // Sparse scatter with backpressure
    v = rand_vec();
    v[63:0] = 64'h0044_0033_0022_0011;
    run_vec(16'h8421, v, 6, 1'b0, '0, '0);
    chk("scatter_lane5", VW'(data_out[5*DATA_W +: DATA_W]), VW'(16'h0022));

    // Empty vector
    run_vec(16'h0000, rand_vec(), 1, 1'b0, '0, '0);

    // Reset mid-expand
    valid_in = 1'b1; index_in = 16'hFFFF; data_in = rand_vec();
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", {255'd0, ready_in}, 1);
    chk("midrst_valid", {255'd0, valid_out}, 0);
    chk("midrst_data", data_out, '0);
    chk("midrst_nnz", VW'(nnz_out), '0);
    tick();
    chk("midrst_no_output", {255'd0, valid_out}, 0);
    run_vec(16'h0003, rand_vec(), 0, 1'b0, '0, '0);

    // Back-to-back with valid_in held; second vector's zero lanes must not see the first
    v = rand_vec();
    run_vec(16'hFFFF, rand_vec(), 2, 1'b1, 16'h0101, v);
    run_vec(16'h0101, v, 0, 1'b0, '0, '0);

    // Randomized vectors
    for (int t = 0; t < 25; t++) begin
      idx = LANES'($urandom);
      if (t % 3 == 1) idx = idx & LANES'($urandom);
      if (t % 7 == 3) idx = '0;
      run_vec(idx, rand_vec(), $urandom_range(0, 3), 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
